vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences VGA/LCD raster timing. Paired horizontal/vertical FSMs (SYNC->BACKPORCH->VISIBLE->FRONTPORCH)
//  driven by the pixel-clock tick from the CTRL.DIV divider. Produces hsync/vsync/de/blank and pixel coordinates.
//  Issues line/frame/vblank event pulses to the STAT/IRQ logic and the framebuffer fetch master.
// PARAMETERS
//  TB_WIDTH  10  width of porch/sync size fields (HTIM/VTIM)
//  VB_WIDTH  16  width of visible-length fields (HVVL) and of the internal phase counters
// PORTS
//  clk_i       in   1         system clock
//  rst_i       in   1         synchronous reset, active-high
//  en_i        in   1         CTRL.EN; 0 holds both FSMs idle
//  tick_i      in   1         pixel-clock enable; 1-cycle pulse from divider
//  hsnsize_i   in   TB_WIDTH  h sync length (ticks)
//  hbpsize_i   in   TB_WIDTH  h back porch length (ticks)
//  hfpsize_i   in   TB_WIDTH  h front porch length (ticks)
//  hvlen_i     in   VB_WIDTH  h visible length (ticks)
//  vsnsize_i   in   TB_WIDTH  v sync length (lines)
//  vbpsize_i   in   TB_WIDTH  v back porch length (lines)
//  vfpsize_i   in   TB_WIDTH  v front porch length (lines)
//  vvlen_i     in   VB_WIDTH  v visible length (lines)
//  hspol_i     in   1         hsync active level
//  vspol_i     in   1         vsync active level
//  blpol_i     in   1         blank active level
//  swap_req_i  in   1         framebuffer swap request pulse (FBBA1<->FBBA2)
//  hsync_o     out  1         horizontal sync
//  vsync_o     out  1         vertical sync
//  de_o        out  1         data enable: h and v both VISIBLE
//  blank_o     out  1         blanking, = blpol_i when ~de_o, else ~blpol_i
//  pix_x_o     out  VB_WIDTH  visible column, 0..hvlen-1, 0 outside visible
//  pix_y_o     out  VB_WIDTH  visible row, 0..vvlen-1, 0 outside visible
//  hend_o      out  1         pulse: last tick of a line
//  vend_o      out  1         pulse: last tick of a frame
//  vbs_o       out  1         pulse: first tick of vertical blanking
//  fbsel_o     out  1         active framebuffer (0=FBBA1, 1=FBBA2)
//  swap_ack_o  out  1         pulse: swap taken effect
// BEHAVIOUR
//  - Reset or en_i=0 (sampled each clk): both FSMs in SYNC; hcnt<=hsnsize_i-1, vcnt<=vsnsize_i-1 (track config).
//    Outputs: hsync_o=~hspol_i, vsync_o=~vspol_i, de_o=0, blank_o=blpol_i, pix_x/y=0, pulses=0.
//    Reset also clears fbsel_o=0 and swap pending; en_i=0 does not.
//  - en_i 1->0 mid-frame: idle state on the next clk, no completion pulses emitted.
//  - Every phase lasts N ticks, N = field value; N=0 treated as 1. Counter loads N-1 on phase entry.
//    The phase advances on tick_i && cnt==0; otherwise cnt decrements on tick_i. No tick => state frozen.
//  - Config fields are sampled only at the counter load for each phase. Mid-phase writes take effect at next phase entry.
//  - H FSM: SYNC->BACKPORCH->VISIBLE->FRONTPORCH->SYNC. hend_o = tick_i && h==FRONTPORCH && hcnt==0.
//  - V FSM: same order; advances/decrements only on hend_o. vcnt counts lines.
//  - vend_o = hend_o && v==FRONTPORCH && vcnt==0.
//  - vbs_o = hend_o && v==VISIBLE && vcnt==0.
//  - Sync/de/blank outputs: registered; they reflect the state entered one clk after the advancing tick.
//    hsync_o=hspol_i while h==SYNC, else ~hspol_i; vsync_o is analogous.
//  - pix_x_o = hvlen-1-hcnt while h==VISIBLE. pix_y_o = vvlen-1-vcnt while v==VISIBLE. Both widths are VB_WIDTH; no wrap beyond.
//  - Pulses are single-cycle, combinational from registered state and tick_i; never asserted when en_i=0.
//  - Totals: line = sum of h fields; frame = line * sum of v fields; arithmetic is modulo VB_WIDTH per counter only.
// CONFIGURATION
//  VGA_TIMCTRL_FBSWAP_EN defined:
//    - swap_req_i sets a sticky pending bit.
//    - At vend_o with pending=1: fbsel_o toggles, pending clears, swap_ack_o pulses in the same cycle.
//    - swap_req_i coincident with vend_o is deferred to the next frame end.
//  Undefined: fbsel_o=0, swap_ack_o=0 constant, swap_req_i ignored.
// TESTING
//  T1 h=2/3/4/1, v=1/1/2/1, tick every clk, en=1 -> hend_o every 10 clk; vend_o every 50 clk; de_o high 4 clk on lines 3,4 only.
//  T2 hspol=0, vspol=1 -> hsync_o low 2 clk per line; vsync_o high for first 10 clk of frame.
//  T3 tick_i every 3rd clk, same config -> all periods x3; pix_x_o steps 0,1,2,3 and each value is held 3 clk.
//  T4 hbpsize=0 -> back porch lasts 1 tick; line = 8 ticks.
//  T5 en_i dropped at pix (2,1) -> next clk de_o=0, sync outputs inactive, no vend_o; re-enable -> frame restarts at h/v SYNC.
//  T6 FBSWAP_EN: swap_req_i at clk 5 -> fbsel_o 0->1 with swap_ack_o at first vend_o; request at vend_o deferred 1 frame.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA/LCD raster timing: paired H/V phase FSMs advanced by the pixel tick, with sync/de/blank and pixel coordinates.
// Optional framebuffer swap handshake is built when VGA_TIMCTRL_FBSWAP_EN is defined.
module vga_timing_ctrl #(
    parameter int TB_WIDTH = 10,
    parameter int VB_WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                tick_i,
    input  logic [TB_WIDTH-1:0] hsnsize_i,
    input  logic [TB_WIDTH-1:0] hbpsize_i,
    input  logic [TB_WIDTH-1:0] hfpsize_i,
    input  logic [VB_WIDTH-1:0] hvlen_i,
    input  logic [TB_WIDTH-1:0] vsnsize_i,
    input  logic [TB_WIDTH-1:0] vbpsize_i,
    input  logic [TB_WIDTH-1:0] vfpsize_i,
    input  logic [VB_WIDTH-1:0] vvlen_i,
    input  logic                hspol_i,
    input  logic                vspol_i,
    input  logic                blpol_i,
    input  logic                swap_req_i,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic                de_o,
    output logic                blank_o,
    output logic [VB_WIDTH-1:0] pix_x_o,
    output logic [VB_WIDTH-1:0] pix_y_o,
    output logic                hend_o,
    output logic                vend_o,
    output logic                vbs_o,
    output logic                fbsel_o,
    output logic                swap_ack_o
);

    typedef enum logic [1:0] {SYNC, BACKPORCH, VISIBLE, FRONTPORCH} phase_e;

    phase_e              h_q, h_d, v_q, v_d;
    logic [VB_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [VB_WIDTH-1:0] hvl_q, hvl_d, vvl_q, vvl_d;
    logic [VB_WIDTH-1:0] pix_x_q, pix_y_q;
    logic                hact_q, vact_q, de_q;
    logic                run;

    // A zero-length field still occupies one tick, so the load value saturates at 0.
    function automatic logic [VB_WIDTH-1:0] tb_load(input logic [TB_WIDTH-1:0] n);
        logic [VB_WIDTH-1:0] v;
        v = VB_WIDTH'(n);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [VB_WIDTH-1:0] vb_load(input logic [VB_WIDTH-1:0] n);
        return (n == '0) ? '0 : n - 1'b1;
    endfunction

    assign run    = en_i && !rst_i;
    assign hend_o = run && tick_i && (h_q == FRONTPORCH) && (hcnt_q == '0);
    assign vend_o = hend_o && (v_q == FRONTPORCH) && (vcnt_q == '0);
    assign vbs_o  = hend_o && (v_q == VISIBLE) && (vcnt_q == '0);

    always_comb begin
        h_d    = h_q;
        hcnt_d = hcnt_q;
        hvl_d  = hvl_q;
        if (!run) begin
            h_d    = SYNC;
            hcnt_d = tb_load(hsnsize_i);
        end else if (tick_i) begin
            if (hcnt_q == '0) begin
                case (h_q)
                    SYNC:       begin h_d = BACKPORCH;  hcnt_d = tb_load(hbpsize_i); end
                    BACKPORCH:  begin h_d = VISIBLE;    hcnt_d = vb_load(hvlen_i); hvl_d = vb_load(hvlen_i); end
                    VISIBLE:    begin h_d = FRONTPORCH; hcnt_d = tb_load(hfpsize_i); end
                    FRONTPORCH: begin h_d = SYNC;       hcnt_d = tb_load(hsnsize_i); end
                endcase
            end else begin
                hcnt_d = hcnt_q - 1'b1;
            end
        end
    end

    // Vertical phases count whole lines, so they only move on the line-end pulse.
    always_comb begin
        v_d    = v_q;
        vcnt_d = vcnt_q;
        vvl_d  = vvl_q;
        if (!run) begin
            v_d    = SYNC;
            vcnt_d = tb_load(vsnsize_i);
        end else if (hend_o) begin
            if (vcnt_q == '0) begin
                case (v_q)
                    SYNC:       begin v_d = BACKPORCH;  vcnt_d = tb_load(vbpsize_i); end
                    BACKPORCH:  begin v_d = VISIBLE;    vcnt_d = vb_load(vvlen_i); vvl_d = vb_load(vvlen_i); end
                    VISIBLE:    begin v_d = FRONTPORCH; vcnt_d = tb_load(vfpsize_i); end
                    FRONTPORCH: begin v_d = SYNC;       vcnt_d = tb_load(vsnsize_i); end
                endcase
            end else begin
                vcnt_d = vcnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        h_q    <= h_d;
        v_q    <= v_d;
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        hvl_q  <= hvl_d;
        vvl_q  <= vvl_d;
    end

    // Outputs are registered from the next state so they line up with the state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            hact_q  <= 1'b0;
            vact_q  <= 1'b0;
            de_q    <= 1'b0;
            pix_x_q <= '0;
            pix_y_q <= '0;
        end else begin
            hact_q  <= (h_d == SYNC);
            vact_q  <= (v_d == SYNC);
            de_q    <= (h_d == VISIBLE) && (v_d == VISIBLE);
            pix_x_q <= (h_d == VISIBLE) ? hvl_d - hcnt_d : '0;
            pix_y_q <= (v_d == VISIBLE) ? vvl_d - vcnt_d : '0;
        end
    end

    assign hsync_o = hact_q ? hspol_i : ~hspol_i;
    assign vsync_o = vact_q ? vspol_i : ~vspol_i;
    assign de_o    = de_q;
    assign blank_o = de_q ? ~blpol_i : blpol_i;
    assign pix_x_o = pix_x_q;
    assign pix_y_o = pix_y_q;

`ifdef VGA_TIMCTRL_FBSWAP_EN
    logic fbsel_q, pend_q;

    // A request landing on the frame end itself is kept pending for the following frame end.
    assign swap_ack_o = vend_o && pend_q;
    assign fbsel_o    = fbsel_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fbsel_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            pend_q <= swap_req_i | (pend_q & ~vend_o);
            if (swap_ack_o) begin
                fbsel_q <= ~fbsel_q;
            end
        end
    end
`else
    logic unused_swap_req;

    assign unused_swap_req = swap_req_i;
    assign fbsel_o         = 1'b0;
    assign swap_ack_o      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: position-based reference model (tick index within line, line within frame).
module tb_vga_timing_ctrl;

`ifdef VGA_TIMCTRL_FBSWAP_EN
    localparam bit FBSW = 1'b1;
`else
    localparam bit FBSW = 1'b0;
`endif

    logic        clk, rst, en, tick, swap_req;
    logic [9:0]  hsn, hbp, hfp, vsn, vbp, vfp;
    logic [15:0] hvl, vvl;
    logic        hspol, vspol, blpol;
    logic        hsync_o, vsync_o, de_o, blank_o, hend_o, vend_o, vbs_o, fbsel_o, swap_ack_o;
    logic [15:0] pix_x_o, pix_y_o;

    int n_pass = 0;
    int n_total = 0;

    int   m_hpos = 0;
    int   m_vline = 0;
    logic m_act = 1'b0;
    logic m_pend = 1'b0;
    logic m_fbsel = 1'b0;

    logic [40:0] exp_v, obs_v;

    vga_timing_ctrl #(.TB_WIDTH(10), .VB_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .tick_i(tick),
        .hsnsize_i(hsn), .hbpsize_i(hbp), .hfpsize_i(hfp), .hvlen_i(hvl),
        .vsnsize_i(vsn), .vbpsize_i(vbp), .vfpsize_i(vfp), .vvlen_i(vvl),
        .hspol_i(hspol), .vspol_i(vspol), .blpol_i(blpol), .swap_req_i(swap_req),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .blank_o(blank_o),
        .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .hend_o(hend_o), .vend_o(vend_o),
        .vbs_o(vbs_o), .fbsel_o(fbsel_o), .swap_ack_o(swap_ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int line_len();
        return eff(int'(hsn)) + eff(int'(hbp)) + eff(int'(hvl)) + eff(int'(hfp));
    endfunction

    function automatic int frame_lines();
        return eff(int'(vsn)) + eff(int'(vbp)) + eff(int'(vvl)) + eff(int'(vfp));
    endfunction

    // 0 sync, 1 back porch, 2 visible, 3 front porch
    function automatic int phase_of(input int pos, input int a, input int b, input int c);
        if (pos < a) return 0;
        if (pos < a + b) return 1;
        if (pos < a + b + c) return 2;
        return 3;
    endfunction

    // {hsync, vsync, de, blank, pix_x, pix_y, hend, vend, vbs, fbsel, ack}
    function automatic logic [40:0] model_out();
        int hs, hb, hv, vs, vb, vv, hph, vph;
        logic de_e, hend_e, vend_e, vbs_e, hs_e, vs_e;
        logic [15:0] px, py;
        hs = eff(int'(hsn)); hb = eff(int'(hbp)); hv = eff(int'(hvl));
        vs = eff(int'(vsn)); vb = eff(int'(vbp)); vv = eff(int'(vvl));
        hph = phase_of(m_hpos, hs, hb, hv);
        vph = phase_of(m_vline, vs, vb, vv);
        de_e = m_act && (hph == 2) && (vph == 2);
        px = (m_act && hph == 2) ? 16'(m_hpos - hs - hb) : 16'd0;
        py = (m_act && vph == 2) ? 16'(m_vline - vs - vb) : 16'd0;
        hend_e = en && !rst && tick && (m_hpos == line_len() - 1);
        vend_e = hend_e && (m_vline == frame_lines() - 1);
        vbs_e = hend_e && (m_vline == vs + vb + vv - 1);
        hs_e = (m_act && hph == 0) ? hspol : ~hspol;
        vs_e = (m_act && vph == 0) ? vspol : ~vspol;
        return {hs_e, vs_e, de_e, (de_e ? ~blpol : blpol), px, py, hend_e, vend_e, vbs_e,
                FBSW & m_fbsel, FBSW & vend_e & m_pend};
    endfunction

    task automatic model_update(input logic vend_e, input logic ack_e);
        if (rst) begin
            m_pend = 1'b0;
            m_fbsel = 1'b0;
        end else begin
            if (ack_e) m_fbsel = ~m_fbsel;
            m_pend = swap_req | (m_pend & ~vend_e);
        end
        if (rst || !en) begin
            m_hpos = 0;
            m_vline = 0;
            m_act = 1'b0;
        end else begin
            m_act = 1'b1;
            if (tick) begin
                if (m_hpos == line_len() - 1) begin
                    m_hpos = 0;
                    m_vline = (m_vline == frame_lines() - 1) ? 0 : m_vline + 1;
                end else begin
                    m_hpos = m_hpos + 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic t, input logic s);
        @(negedge clk);
        rst = r; en = e; tick = t; swap_req = s;
        #1;
        exp_v = model_out();
        obs_v = {hsync_o, vsync_o, de_o, blank_o, pix_x_o, pix_y_o, hend_o, vend_o, vbs_o, fbsel_o, swap_ack_o};
        model_update(exp_v[3], exp_v[0]);
    endtask

    task automatic set_cfg(input int a, input int b, input int c, input int d,
                           input int e, input int f, input int g, input int h);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        hsn = 10'(a); hbp = 10'(b); hvl = 16'(c); hfp = 10'(d);
        vsn = 10'(e); vbp = 10'(f); vvl = 16'(g); vfp = 10'(h);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL reset_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            n_total++;
            if ({de_o, blank_o, fbsel_o, hsync_o} !== {1'b0, blpol, 1'b0, ~hspol})
                $display("FAIL reset_idle got=%b exp=%b", {de_o, blank_o, fbsel_o, hsync_o}, {1'b0, blpol, 1'b0, ~hspol});
            else n_pass++;
        end
    endtask

    task automatic test_t1_timing();
        int last_h, last_v, de_cnt, nv;
        last_h = -1; last_v = -1; de_cnt = 0; nv = 0;
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        for (int i = 0; i < 160; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t1_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (nv >= 1 && de_o) de_cnt++;
            if (hend_o) begin
                if (last_h >= 0) begin
                    n_total++;
                    if (i - last_h != 10) $display("FAIL t1_hend_period got=%0d exp=10", i - last_h);
                    else n_pass++;
                end
                last_h = i;
            end
            if (vend_o) begin
                nv++;
                if (last_v >= 0) begin
                    n_total++;
                    if (i - last_v != 50) $display("FAIL t1_vend_period got=%0d exp=50", i - last_v);
                    else n_pass++;
                    n_total++;
                    if (de_cnt != 8) $display("FAIL t1_de_per_frame got=%0d exp=8", de_cnt);
                    else n_pass++;
                end
                de_cnt = 0;
                last_v = i;
            end
        end
    endtask

    task automatic test_polarity();
        int nv, hlow, vhigh;
        nv = 0; hlow = 0; vhigh = 0;
        hspol = 1'b0; vspol = 1'b1; blpol = 1'b0;
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        for (int i = 0; i < 120; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t2_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (nv == 1) begin
                if (!hsync_o) hlow++;
                if (vsync_o) vhigh++;
            end
            if (vend_o) begin
                nv++;
                if (nv == 2) begin
                    n_total++;
                    if (hlow != 10 || vhigh != 10)
                        $display("FAIL t2_sync_widths got=%0d/%0d exp=10/10", hlow, vhigh);
                    else n_pass++;
                end
            end
        end
        hspol = 1'b1; vspol = 1'b0; blpol = 1'b1;
    endtask

    task automatic test_tick_div();
        int last_h, run_len;
        logic [15:0] last_px;
        last_h = -1; run_len = 0; last_px = '0;
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        for (int i = 0; i < 330; i++) begin
            step(1'b0, 1'b1, (i % 3) == 0, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t3_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (de_o) begin
                if (run_len > 0 && pix_x_o != last_px) begin
                    n_total++;
                    if (run_len != 3) $display("FAIL t3_pix_hold got=%0d exp=3", run_len);
                    else n_pass++;
                    run_len = 1;
                end else begin
                    run_len++;
                end
                last_px = pix_x_o;
            end else if (run_len > 0) begin
                n_total++;
                if (run_len != 3 || last_px != 16'd3) $display("FAIL t3_pix_last got=%0d/%0d exp=3/3", run_len, last_px);
                else n_pass++;
                run_len = 0;
            end
            if (hend_o) begin
                if (last_h >= 0) begin
                    n_total++;
                    if (i - last_h != 30) $display("FAIL t3_hend_period got=%0d exp=30", i - last_h);
                    else n_pass++;
                end
                last_h = i;
            end
        end
    endtask

    task automatic test_zero_bp();
        int last_h;
        last_h = -1;
        set_cfg(2, 0, 4, 1, 1, 0, 2, 1);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t4_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (hend_o) begin
                if (last_h >= 0) begin
                    n_total++;
                    if (i - last_h != 8) $display("FAIL t4_hend_period got=%0d exp=8", i - last_h);
                    else n_pass++;
                end
                last_h = i;
            end
        end
    endtask

    task automatic test_en_drop();
        logic found;
        found = 1'b0;
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t5_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (de_o && pix_x_o == 16'd2 && pix_y_o == 16'd1) found = 1'b1;
        end
        n_total++;
        if (!found) $display("FAIL t5_reach_pix got=timeout exp=pix(2,1)");
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t5_idle_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({de_o, hsync_o, vsync_o, vend_o} !== {1'b0, ~hspol, ~vspol, 1'b0})
                    $display("FAIL t5_idle_outputs got=%b exp=%b", {de_o, hsync_o, vsync_o, vend_o}, {1'b0, ~hspol, ~vspol, 1'b0});
                else n_pass++;
            end
        end
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t5_restart_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if ({hsync_o, vsync_o} !== {hspol, vspol})
                    $display("FAIL t5_restart_sync got=%b exp=%b", {hsync_o, vsync_o}, {hspol, vspol});
                else n_pass++;
            end
        end
    endtask

    task automatic test_fbswap();
        int nv, stage;
        logic s, pred_vend;
        nv = 0; stage = 0;
        set_cfg(2, 3, 4, 1, 1, 1, 2, 1);
        for (int i = 0; i < 260; i++) begin
            pred_vend = (m_hpos == line_len() - 1) && (m_vline == frame_lines() - 1) && m_act;
            s = (i == 5) || (stage == 1 && pred_vend);
            step(1'b0, 1'b1, 1'b1, s);
            n_total++;
            if (obs_v !== exp_v) $display("FAIL t6_bundle cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
            else n_pass++;
`ifdef VGA_TIMCTRL_FBSWAP_EN
            if (vend_o) begin
                nv++;
                n_total++;
                if (nv == 1 && swap_ack_o !== 1'b1) $display("FAIL t6_first_ack got=%b exp=1", swap_ack_o);
                else if (nv == 2 && swap_ack_o !== 1'b0) $display("FAIL t6_deferred_ack got=%b exp=0", swap_ack_o);
                else if (nv == 3 && swap_ack_o !== 1'b1) $display("FAIL t6_late_ack got=%b exp=1", swap_ack_o);
                else n_pass++;
                if (nv == 1) stage = 1;
                else if (nv == 2) stage = 2;
            end
            if (i == 60) begin
                n_total++;
                if (fbsel_o !== 1'b1) $display("FAIL t6_fbsel_toggled got=%b exp=1", fbsel_o);
                else n_pass++;
            end
`else
            if (s || vend_o) begin
                n_total++;
                if ({fbsel_o, swap_ack_o} !== 2'b00) $display("FAIL t6_swap_disabled got=%b exp=00", {fbsel_o, swap_ack_o});
                else n_pass++;
            end
            if (vend_o) begin
                nv++;
                stage = (nv == 1) ? 1 : 2;
            end
`endif
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            hspol = 1'($urandom_range(0, 1));
            vspol = 1'($urandom_range(0, 1));
            blpol = 1'($urandom_range(0, 1));
            set_cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
            for (int i = 0; i < 400; i++) begin
                step($urandom_range(0, 499) == 0, $urandom_range(0, 299) != 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
                n_total++;
                if (obs_v !== exp_v) $display("FAIL rand_bundle cfg=%0d cyc=%0d got=%h exp=%h", k, i, obs_v, exp_v);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; tick = 1'b0; swap_req = 1'b0;
        hsn = 10'd2; hbp = 10'd3; hvl = 16'd4; hfp = 10'd1;
        vsn = 10'd1; vbp = 10'd1; vvl = 16'd2; vfp = 10'd1;
        hspol = 1'b1; vspol = 1'b0; blpol = 1'b1;
        @(negedge clk);
        test_reset();
        test_t1_timing();
        test_polarity();
        test_tick_div();
        test_zero_bp();
        test_en_drop();
        test_fbswap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
